// File: rtl/lcd_timing_pkg.sv
// Shared constants, widths and state encoding for the 800x480 LCD timing generator.
// Defaults describe the panel; the top level may override them per instance.
package lcd_timing_pkg;

    localparam int H_W = 11;
    localparam int V_W = 10;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 128;
    localparam int DEF_H_BP     = 88;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 13;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 29;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int DEF_LOCK_HOLD = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } state_t;

    // True when a total count of 'total' states fits a counter of 'width' bits.
    function automatic bit fits(input int total, input int width);
        return (total > 0) && (total <= (1 << width));
    endfunction

endpackage

// File: rtl/lcd_timing_gen_lock_qualifier.sv
// PLL lock qualifier: synchronizes the lock, demands a stable hold period,
// then reports RUN; any loss of synchronized lock falls back to IDLE.
module lock_qualifier
    import lcd_timing_pkg::*;
#(
    parameter int LOCK_HOLD = DEF_LOCK_HOLD
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pll_lock,
    output logic o_running,
    output logic o_start
);

    localparam int CW = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(LOCK_HOLD - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    state_t        r_state;
    logic          w_lock_s;

    assign w_lock_s  = r_sync[1];
    assign o_running = (r_state == RUN);
    assign o_start   = (r_state == HOLD) && w_lock_s && (r_cnt == HOLD_LAST);

    // Synchronizer, hold counter and IDLE/HOLD/RUN state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_cnt   <= '0;
            r_state <= IDLE;
        end else begin
            r_sync <= {r_sync[0], i_pll_lock};
            unique case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_lock_s) r_state <= HOLD;
                end
                HOLD: begin
                    if (!w_lock_s)              r_state <= IDLE;
                    else if (r_cnt == HOLD_LAST) r_state <= RUN;
                    else                        r_cnt   <= r_cnt + CW'(1);
                end
                RUN: begin
                    if (!w_lock_s) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_timing_gen.sv
// Video timing generator: h/v raster counters plus registered sync, DE,
// coordinate and start-pulse outputs, gated by the lock qualifier.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int   H_ACTIVE  = DEF_H_ACTIVE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_ACTIVE  = DEF_V_ACTIVE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic SYNC_POL  = 1'b0,
    parameter int   LOCK_HOLD = DEF_LOCK_HOLD
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pll_lock,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic [H_W-1:0] x,
    output logic [V_W-1:0] y,
    output logic           line_start,
    output logic           frame_start,
    output logic           running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (!fits(H_TOTAL, H_W) || !fits(V_TOTAL, V_W) || LOCK_HOLD < 1
        || H_ACTIVE < 1 || V_ACTIVE < 1 || H_SYNC < 1 || V_SYNC < 1) begin : g_bad_params
        $error("lcd_timing_gen: timing parameters do not fit the counters");
    end

    // One extra bit so a window end equal to 2**width still compares correctly.
    localparam logic [H_W:0]   HA    = (H_W+1)'(H_ACTIVE);
    localparam logic [H_W:0]   HS_B  = (H_W+1)'(H_ACTIVE + H_FP);
    localparam logic [H_W:0]   HS_E  = (H_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [H_W-1:0] H_LST = H_W'(H_TOTAL - 1);
    localparam logic [V_W:0]   VA    = (V_W+1)'(V_ACTIVE);
    localparam logic [V_W:0]   VS_B  = (V_W+1)'(V_ACTIVE + V_FP);
    localparam logic [V_W:0]   VS_E  = (V_W+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [V_W-1:0] V_LST = V_W'(V_TOTAL - 1);

    logic           w_run;
    logic           w_start;
    logic [H_W-1:0] r_h;
    logic [V_W-1:0] r_v;
    logic [H_W:0]   w_h;
    logic [V_W:0]   w_v;
    logic           w_de;
    logic           w_hs;
    logic           w_vs;
    logic           w_ls;
    logic           w_fs;

    logic           r_hsync;
    logic           r_vsync;
    logic           r_de;
    logic [H_W-1:0] r_x;
    logic [V_W-1:0] r_y;
    logic           r_ls;
    logic           r_fs;
    logic           r_running;

    lock_qualifier #(
        .LOCK_HOLD (LOCK_HOLD)
    ) u_lock (
        .clk        (clk),
        .rst        (rst),
        .i_pll_lock (pll_lock),
        .o_running  (w_run),
        .o_start    (w_start)
    );

    // Raster counters; parked at the origin unless running so a relock
    // always begins a fresh frame.
    always_ff @(posedge clk) begin
        if (rst || !w_run || w_start) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == H_LST) begin
            r_h <= '0;
            r_v <= (r_v == V_LST) ? '0 : r_v + V_W'(1);
        end else begin
            r_h <= r_h + H_W'(1);
        end
    end

    assign w_h  = {1'b0, r_h};
    assign w_v  = {1'b0, r_v};
    assign w_de = (w_h < HA) && (w_v < VA);
    assign w_hs = (w_h >= HS_B) && (w_h < HS_E);
    assign w_vs = (w_v >= VS_B) && (w_v < VS_E);
    assign w_ls = (r_h == '0) && (w_v < VA);
    assign w_fs = (r_h == '0) && (r_v == '0);

    // Output registers; everything reads inactive whenever not running.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync   <= ~SYNC_POL;
            r_vsync   <= ~SYNC_POL;
            r_de      <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_ls      <= 1'b0;
            r_fs      <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_hsync   <= (w_run && w_hs) ? SYNC_POL : ~SYNC_POL;
            r_vsync   <= (w_run && w_vs) ? SYNC_POL : ~SYNC_POL;
            r_de      <= w_run && w_de;
            r_x       <= (w_run && w_de) ? r_h : '0;
            r_y       <= (w_run && w_de) ? r_v : '0;
            r_ls      <= w_run && w_ls;
            r_fs      <= w_run && w_fs;
            r_running <= w_run;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_ls;
    assign frame_start = r_fs;
    assign running     = r_running;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Scoreboard bench for lcd_timing_gen with a short lock hold and a short
// vertical raster (full 1056-clock lines, 13-line frames).
module tb_lcd_timing_gen;

    localparam int HT    = 1056;
    localparam int VA    = 6;
    localparam int VT    = 13;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [10:0] x;
        logic [9:0]  y;
        logic        ls;
        logic        fs;
        logic        run;
    } out_t;

    bit          clk = 1'b0;
    logic        rst;
    logic        pll_lock;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [10:0] x;
    logic [9:0]  y;
    logic        line_start;
    logic        frame_start;
    logic        running;

    out_t exp_q[$];
    int   meas_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   fs_cyc = 0;
    int   ls_cnt = 0;
    bit   fs_seen = 1'b0;
    out_t e;
    out_t a;
    int   want_per;
    int   want_ls;

    always #5 clk = ~clk;

    lcd_timing_gen #(
        .V_ACTIVE  (6),
        .V_FP      (2),
        .V_SYNC    (3),
        .V_BP      (2),
        .LOCK_HOLD (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_lock    (pll_lock),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .x           (x),
        .y           (y),
        .line_start  (line_start),
        .frame_start (frame_start),
        .running     (running)
    );

    function automatic out_t idle_v();
        out_t o;
        o    = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        return o;
    endfunction

    // Expected outputs k clocks after the first active pixel (0,0).
    // hsync low h=840..967, vsync low on lines 8..10.
    function automatic out_t pix(input int k);
        out_t o;
        int   h;
        int   v;
        h     = k % HT;
        v     = (k / HT) % VT;
        o     = '0;
        o.run = 1'b1;
        o.de  = (h < 800) && (v < VA);
        o.x   = o.de ? 11'(h) : 11'd0;
        o.y   = o.de ? 10'(v) : 10'd0;
        o.hs  = !((h >= 840) && (h < 968));
        o.vs  = !((v >= 8) && (v < 11));
        o.ls  = (h == 0) && (v < VA);
        o.fs  = (h == 0) && (v == 0);
        return o;
    endfunction

    task automatic tick(input logic l, input logic r, input int k);
        rst      = r;
        pll_lock = l;
        exp_q.push_back((k < 0) ? idle_v() : pix(k));
        @(posedge clk);
        #1;
    endtask

    // Monitor: per-cycle output check plus frame period / line count.
    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {hsync, vsync, de, x, y, line_start, frame_start, running};
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL outputs cyc=%0d got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b run=%b want hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b run=%b",
                    cyc, a.hs, a.vs, a.de, a.x, a.y, a.ls, a.fs, a.run,
                    e.hs, e.vs, e.de, e.x, e.y, e.ls, e.fs, e.run);
            end
        end
        if (running !== 1'b1) begin
            fs_seen = 1'b0;
        end else if (frame_start === 1'b1) begin
            if (fs_seen) begin
                n_cmp++;
                if (meas_q.size() < 2) begin
                    n_err++;
                    $display("FAIL frame_meas got period=%0d lines=%0d want no measurement",
                        cyc - fs_cyc, ls_cnt);
                end else begin
                    want_per = meas_q.pop_front();
                    want_ls  = meas_q.pop_front();
                    if ((cyc - fs_cyc) != want_per || ls_cnt != want_ls) begin
                        n_err++;
                        $display("FAIL frame_meas got period=%0d lines=%0d want period=%0d lines=%0d",
                            cyc - fs_cyc, ls_cnt, want_per, want_ls);
                    end
                end
            end
            fs_seen = 1'b1;
            fs_cyc  = cyc;
            ls_cnt  = 0;
        end
        if (running === 1'b1 && line_start === 1'b1) ls_cnt++;
    end

    initial begin
        int k0;
        int kr;
        rst      = 1'b1;
        pll_lock = 1'b0;
        repeat (3) tick(1'b0, 1'b1, -1);

        // Lock from edge 0: first active pixel after edge 20.
        meas_q.push_back(FRAME);
        meas_q.push_back(VA);
        for (int j = 1; j <= 19; j++) tick(1'b1, 1'b0, -1);
        k0 = FRAME + 3 * HT + 400;
        for (int k = 0; k < k0; k++) tick(1'b1, 1'b0, k);

        // Lock loss at pixel (400,3): three more active clocks, then idle.
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, k0 + i);
        repeat (5) tick(1'b0, 1'b0, -1);

        // Relock with a one-clock dropout during HOLD: hold restarts.
        for (int j = 1; j <= 28; j++) tick((j == 9) ? 1'b0 : 1'b1, 1'b0, -1);
        kr = (VA - 1) * HT + 799;
        for (int k = 0; k <= kr; k++) tick(1'b1, 1'b0, k);

        // Reset at the last visible pixel, lock still high.
        repeat (3) tick(1'b1, 1'b1, -1);
        for (int j = 1; j <= 19; j++) tick(1'b1, 1'b0, -1);
        for (int k = 0; k <= 2 * HT + 50; k++) tick(1'b1, 1'b0, k);

        @(negedge clk);
        #1;
        n_cmp++;
        if (meas_q.size() != 0) begin
            n_err++;
            $display("FAIL meas_pending got %0d want 0", meas_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
